llr_frame_buffer: RTL and testbench

Parametrised serial-to-parallel channel LLR buffer for the SCAN polar decoder front end. It accepts channel LLRs `LANES` at a time over a valid/ready handshake and assembles them into P-wide groups in two ping-pong banks. Each group is presented to the decoder over a second valid/ready handshake, tagged with its group index within an N-bit frame. Input continues while the decoder consumes the previous group, and frame delimiters are checked for alignment.

---
 rtl/polar_pkg.sv | 22 ++
 rtl/llr_shift_bank.sv | 33 +++
 rtl/llr_frame_buffer.sv | 123 ++++++++++++
 tb/tb_llr_frame_buffer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/polar_pkg.sv
// Shared definitions for the SCAN polar decoder front end.
//   Q, P, N : default LLR width, group width and code length
//   G       : groups per frame for the defaults
//   GW      : group-index width for the defaults (at least 1 bit)
//   llr_t   : one signed channel LLR
//   idx_w() : index width for a count of items, never below 1 bit
package polar_pkg;

  localparam int unsigned Q = 6;
  localparam int unsigned P = 128;
  localparam int unsigned N = 1024;
  localparam int unsigned G = N / P;

  function automatic int unsigned idx_w(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  localparam int unsigned GW = idx_w(G);

  typedef logic signed [Q-1:0] llr_t;

endpackage

// File: rtl/llr_shift_bank.sv
// One P*Q-bit LLR bank filled by shifting.
//   clk      : clock
//   clr      : synchronous clear of the whole bank
//   shift_en : shift the bank down by LANES*Q bits and insert ins at the top
//   ins      : LANES LLRs, lane 0 in the low bits (earliest in channel order)
//   data     : bank contents; after P/LANES shifts the first LLR sits at [Q-1:0]
module llr_shift_bank #(
  parameter int unsigned Q     = 6,
  parameter int unsigned P     = 128,
  parameter int unsigned LANES = 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               shift_en,
  input  logic [LANES*Q-1:0] ins,
  output logic [P*Q-1:0]     data
);

  generate
    if (LANES == P) begin : g_full_width
      always_ff @(posedge clk) begin
        if (clr)           data <= '0;
        else if (shift_en) data <= ins;
      end
    end else begin : g_shift
      always_ff @(posedge clk) begin
        if (clr)           data <= '0;
        else if (shift_en) data <= {ins, data[P*Q-1:LANES*Q]};
      end
    end
  endgenerate

endmodule

// File: rtl/llr_frame_buffer.sv
// Serial-to-parallel channel LLR buffer with two ping-pong banks.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input beat handshake, LANES LLRs per beat on in_llr
//   in_last             : final beat of a frame, checked for alignment
//   out_valid/out_ready : group handshake towards the decoder
//   out_llr             : P LLRs, LLR k at [(k+1)Q-1:kQ]
//   out_group           : group index within the frame
//   out_last            : group is the last of its frame
//   frame_err           : sticky misaligned in_last flag, cleared by rst only
module llr_frame_buffer
  import polar_pkg::idx_w;
#(
  parameter int unsigned Q     = polar_pkg::Q,
  parameter int unsigned P     = polar_pkg::P,
  parameter int unsigned N     = polar_pkg::N,
  parameter int unsigned LANES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*Q-1:0]        in_llr,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [P*Q-1:0]            out_llr,
  output logic [idx_w(N/P)-1:0]     out_group,
  output logic                      out_last,
  output logic                      frame_err
);

  localparam int unsigned G     = N / P;
  localparam int unsigned GW    = idx_w(G);
  localparam int unsigned BEATS = P / LANES;
  localparam int unsigned BW    = idx_w(BEATS);

  generate
    if (N % P != 0) begin : g_bad_n
      $error("llr_frame_buffer: N must be a multiple of P");
    end
    if (LANES == 0 || (LANES & (LANES - 1)) != 0 || P % LANES != 0) begin : g_bad_lanes
      $error("llr_frame_buffer: LANES must be a power of two dividing P");
    end
  endgenerate

  logic [BW-1:0] beat_cnt;
  logic [GW-1:0] grp_cnt;
  logic          fill_ptr;
  logic          rd_ptr;
  logic [1:0]    full_cnt;
  logic [GW-1:0] bank_grp [2];
  logic [1:0]    bank_last;
  logic [P*Q-1:0] bank_data [2];

  logic in_acc, out_acc, beat_end, frame_end, bad_last, grp_done;
  logic [1:0] shift_en;

  assign in_ready  = !rst && (full_cnt < 2'd2);
  assign out_valid = (full_cnt != 2'd0);
  assign out_llr   = bank_data[rd_ptr];
  assign out_group = bank_grp[rd_ptr];
  assign out_last  = bank_last[rd_ptr];

  always_comb begin
    in_acc    = in_valid && in_ready;
    out_acc   = out_valid && out_ready;
    beat_end  = (beat_cnt == BW'(BEATS - 1));
    frame_end = beat_end && (grp_cnt == GW'(G - 1));
    // A misplaced in_last discards the partial bank even on a group's last beat.
    bad_last  = in_acc && in_last && !frame_end;
    grp_done  = in_acc && beat_end && !bad_last;
    shift_en  = '0;
    shift_en[fill_ptr] = in_acc;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    llr_shift_bank #(
      .Q(Q),
      .P(P),
      .LANES(LANES)
    ) u_bank (
      .clk(clk),
      .clr(rst),
      .shift_en(shift_en[b]),
      .ins(in_llr),
      .data(bank_data[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      grp_cnt   <= '0;
      fill_ptr  <= 1'b0;
      rd_ptr    <= 1'b0;
      full_cnt  <= '0;
      bank_grp  <= '{default: '0};
      bank_last <= '0;
      frame_err <= 1'b0;
    end else begin
      if (in_acc) begin
        if (bad_last || beat_end) beat_cnt <= '0;
        else                      beat_cnt <= beat_cnt + 1'b1;
      end

      if (bad_last) begin
        grp_cnt   <= '0;
        frame_err <= 1'b1;
      end else if (grp_done) begin
        grp_cnt             <= (grp_cnt == GW'(G - 1)) ? '0 : grp_cnt + 1'b1;
        fill_ptr            <= ~fill_ptr;
        bank_grp[fill_ptr]  <= grp_cnt;
        bank_last[fill_ptr] <= (grp_cnt == GW'(G - 1));
      end

      if (out_acc) rd_ptr <= ~rd_ptr;

      if (grp_done && !out_acc)      full_cnt <= full_cnt + 2'd1;
      else if (!grp_done && out_acc) full_cnt <= full_cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_llr_frame_buffer.sv
module tb_llr_frame_buffer;

  localparam int unsigned Q     = 6;
  localparam int unsigned P     = 8;
  localparam int unsigned N     = 32;
  localparam int unsigned LANES = 2;
  localparam int unsigned G     = N / P;
  localparam int unsigned GW    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*Q-1:0]   in_llr;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [P*Q-1:0]       out_llr;
  logic [GW-1:0]        out_group;
  logic                 out_last;
  logic                 frame_err;

  llr_frame_buffer #(
    .Q(Q),
    .P(P),
    .N(N),
    .LANES(LANES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_llr(in_llr),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_llr(out_llr),
    .out_group(out_group),
    .out_last(out_last),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: completed groups waiting for the decoder, plus the
  // LLRs collected so far for the group being assembled.
  logic [P*Q-1:0] pend_llr [$];
  int             pend_grp [$];
  logic           pend_last[$];
  logic [Q-1:0]   part     [$];
  int             m_grp;
  logic           m_err;
  logic           m_clean;

  function automatic logic want_last();
    return (part.size() + LANES == P) && (m_grp == G - 1);
  endfunction

  task automatic model_reset();
    pend_llr.delete();
    pend_grp.delete();
    pend_last.delete();
    part.delete();
    m_grp   = 0;
    m_err   = 1'b0;
    m_clean = 1'b1;
  endtask

  task automatic step(input logic r, input logic v, input logic [LANES*Q-1:0] d,
                      input logic l, input logic ordy);
    logic m_ready, acc_in, acc_out;
    logic [P*Q-1:0] vec;
    rst       = r;
    in_valid  = v;
    in_llr    = d;
    in_last   = l;
    out_ready = ordy;
    m_ready = !r && (pend_llr.size() < 2);
    acc_in  = v && m_ready;
    acc_out = !r && (pend_llr.size() > 0) && ordy;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (acc_out) begin
        void'(pend_llr.pop_front());
        void'(pend_grp.pop_front());
        void'(pend_last.pop_front());
      end
      if (acc_in) begin
        m_clean = 1'b0;
        for (int j = 0; j < LANES; j++) part.push_back(d[j*Q +: Q]);
        if (l && !(part.size() == P && m_grp == G - 1)) begin
          m_err = 1'b1;
          part.delete();
          m_grp = 0;
        end else if (part.size() == P) begin
          vec = '0;
          for (int k = 0; k < P; k++) vec[k*Q +: Q] = part[k];
          pend_llr.push_back(vec);
          pend_grp.push_back(m_grp);
          pend_last.push_back(m_grp == G - 1);
          m_grp = (m_grp + 1) % G;
          part.delete();
        end
      end
    end
    @(negedge clk);
    chk("in_ready",  64'(in_ready),  64'(!rst && pend_llr.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(pend_llr.size() > 0));
    chk("frame_err", 64'(frame_err), 64'(m_err));
    if (pend_llr.size() > 0) begin
      chk("out_llr",   64'(out_llr),   64'(pend_llr[0]));
      chk("out_group", 64'(out_group), 64'(pend_grp[0]));
      chk("out_last",  64'(out_last),  64'(pend_last[0]));
    end else if (m_clean) begin
      chk("out_llr_rst",   64'(out_llr),   64'd0);
      chk("out_group_rst", 64'(out_group), 64'd0);
      chk("out_last_rst",  64'(out_last),  64'd0);
    end
  endtask

  function automatic logic [LANES*Q-1:0] inc_beat(input int b);
    logic [LANES*Q-1:0] d;
    for (int j = 0; j < LANES; j++) d[j*Q +: Q] = Q'(b * LANES + j);
    return d;
  endfunction

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int cycles, input logic ordy);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, '0, 1'b0, ordy);
  endtask

  initial begin
    int b;
    logic lst;
    rst = 1'b1; in_valid = 1'b0; in_llr = '0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset and idle
    do_reset(3);
    idle(2, 1'b0);

    // Streaming frame with incrementing LLRs, decoder always ready
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, inc_beat(i), i == 15, 1'b1);
    idle(3, 1'b1);

    // Backpressure: both banks fill, then a single accept pulse
    do_reset(1);
    b = 0;
    for (int i = 0; i < 12; i++) begin
      lst = want_last();
      if (pend_llr.size() < 2) begin
        step(1'b0, 1'b1, inc_beat(b), lst, 1'b0);
        b++;
      end else begin
        step(1'b0, 1'b1, inc_beat(b), lst, 1'b0);
      end
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(3, 1'b0);
    idle(3, 1'b1);

    // Group 1 completes in the same cycle group 0 is accepted
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, inc_beat(i), 1'b0, i == 7);
    idle(3, 1'b1);

    // Misaligned in_last on beat 6, then a fresh group 0
    do_reset(1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, inc_beat(i), i == 5, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, inc_beat(i + 20), 1'b0, 1'b1);
    idle(4, 1'b1);

    // Reset mid-frame with one group pending
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, inc_beat(i), 1'b0, 1'b0);
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, inc_beat(i + 8), 1'b0, 1'b0);
    chk("grp_after_rst", 64'(out_group), 64'd0);
    idle(3, 1'b1);

    // Randomised traffic with occasional misplaced or missing in_last
    do_reset(1);
    for (int i = 0; i < 800; i++) begin
      int unsigned pick;
      pick = $urandom % 40;
      if (pick == 0)      lst = 1'b1;
      else if (pick == 1) lst = 1'b0;
      else                lst = want_last();
      step(1'b0, ($urandom % 10) < 7, LANES*Q'($urandom), lst, ($urandom % 2) == 0);
      if (i == 400) do_reset(1);
    end
    idle(4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
